// File: rtl/rv32imc_types.sv
// Shared types for the rv32imc memory subsystem: memory request record and arbiter FSM states.
package rv32imc_types;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } mem_arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_MASK_W-1:0] rmask;
        logic [MEM_MASK_W-1:0] wmask;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    function automatic logic req_active(input mem_req_t r);
        return |{r.rmask, r.wmask};
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One pending-request slot: captures a request pulse, offers it (or a same-cycle bypass) for
// issue, and flags requests that arrive while the side already has one in flight.
module mem_req_slot
    import rv32imc_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  mem_req_t req,
    input  logic     busy,
    input  logic     issue,
    output logic     eligible,
    output mem_req_t entry,
    output logic     drop
);

    logic     valid_q, valid_d;
    mem_req_t req_q, req_d;
    logic     req_valid;
    logic     accept;

    always_comb begin
        req_valid = req_active(req);
        // busy means outstanding and not completing this cycle
        drop      = req_valid && (valid_q || busy);
        accept    = req_valid && !drop;
        eligible  = valid_q || accept;
        entry     = valid_q ? req_q : req;

        valid_d = valid_q;
        req_d   = req_q;
        if (issue) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            req_d   = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates imem and dmem requests onto one single-outstanding memory port.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise dmem has fixed priority.
module mem_arbiter
    import rv32imc_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   imem_addr,
    input  logic [DATA_W/8-1:0] imem_rmask,
    output logic [DATA_W-1:0]   imem_rdata,
    output logic                imem_resp,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W/8-1:0] dmem_rmask,
    input  logic [DATA_W/8-1:0] dmem_wmask,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                dmem_resp,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_rmask,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp,
    output logic                proto_err
);

    // ADDR_W/DATA_W must match the widths fixed in rv32imc_types
    mem_arb_state_t state_q, state_d;
    mem_req_t       imem_req, dmem_req, entry_i, entry_d, sel;
    logic           elig_i, elig_d, drop_i, drop_d;
    logic           busy_i, busy_d;
    logic           issue_i, issue_d;
    logic           prefer_d, grant_d;
    logic           proto_err_q;

    assign imem_req = '{addr: imem_addr, rmask: imem_rmask, wmask: '0, wdata: '0};
    assign dmem_req = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

    assign busy_i = (state_q == BUSY_I) && !mem_resp;
    assign busy_d = (state_q == BUSY_D) && !mem_resp;

    mem_req_slot u_slot_i (
        .clk      (clk),
        .rst      (rst),
        .req      (imem_req),
        .busy     (busy_i),
        .issue    (issue_i),
        .eligible (elig_i),
        .entry    (entry_i),
        .drop     (drop_i)
    );

    mem_req_slot u_slot_d (
        .clk      (clk),
        .rst      (rst),
        .req      (dmem_req),
        .busy     (busy_d),
        .issue    (issue_d),
        .eligible (elig_d),
        .entry    (entry_d),
        .drop     (drop_d)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    assign prefer_d = (last_grant_q == GRANT_I);

    always_comb begin
        last_grant_d = last_grant_q;
        if (issue_d) begin
            last_grant_d = GRANT_D;
        end else if (issue_i) begin
            last_grant_d = GRANT_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign prefer_d = 1'b1;
`endif

    assign grant_d = elig_d && (prefer_d || !elig_i);
    assign sel     = grant_d ? entry_d : entry_i;

    always_comb begin
        state_d   = state_q;
        issue_i   = 1'b0;
        issue_d   = 1'b0;
        imem_resp = 1'b0;
        dmem_resp = 1'b0;
        mem_addr  = sel.addr;
        mem_wdata = sel.wdata;
        mem_rmask = '0;
        mem_wmask = '0;
        unique case (state_q)
            IDLE: begin
                if (!rst && (elig_i || elig_d)) begin
                    mem_rmask = sel.rmask;
                    mem_wmask = sel.wmask;
                    issue_d   = grant_d;
                    issue_i   = !grant_d;
                    state_d   = grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                if (!rst && mem_resp) begin
                    imem_resp = 1'b1;
                    state_d   = IDLE;
                end
            end
            BUSY_D: begin
                if (!rst && mem_resp) begin
                    dmem_resp = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;
    assign proto_err  = proto_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_q | drop_i | drop_d;
        end
    end

endmodule
